// File: rtl/cache_pkg.sv
// Shared types and bus-message layout helpers for the snooping cache.
// The message layout is {id, op, addr}, with addr in the low bits.
package cache_pkg;

  typedef enum logic {
    BUS_READ  = 1'b0,
    BUS_WRITE = 1'b1
  } bus_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_RESP
  } state_e;

  function automatic int unsigned msg_width(input int unsigned id_w, input int unsigned addr_w);
    return id_w + 1 + addr_w;
  endfunction

  function automatic int unsigned msg_op_bit(input int unsigned addr_w);
    return addr_w;
  endfunction

  function automatic int unsigned msg_id_lsb(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Direct-mapped valid/tag/data arrays with one lookup+write port and one snoop-invalidate port.
// When a snoop invalidate and a local write land on the same edge, the write wins.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned SET_COUNT  = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LINE_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                  lookup_hit_o,
  output logic [LINE_WIDTH-1:0] lookup_data_o,
  input  logic                  wr_en_i,
  input  logic [LINE_WIDTH-1:0] wr_data_i,
  input  logic                  inv_en_i,
  input  logic [ADDR_WIDTH-1:0] inv_addr_i
);

  localparam int unsigned IdxW = $clog2(SET_COUNT);
  localparam int unsigned TagW = ADDR_WIDTH - IdxW;

  logic [SET_COUNT-1:0]  valid_q, valid_d;
  logic [TagW-1:0]       tag_q  [SET_COUNT];
  logic [LINE_WIDTH-1:0] data_q [SET_COUNT];

  logic [IdxW-1:0] lk_idx, inv_idx;
  logic [TagW-1:0] lk_tag, inv_tag;
  logic            inv_match;

  assign lk_idx  = lookup_addr_i[IdxW-1:0];
  assign lk_tag  = lookup_addr_i[ADDR_WIDTH-1:IdxW];
  assign inv_idx = inv_addr_i[IdxW-1:0];
  assign inv_tag = inv_addr_i[ADDR_WIDTH-1:IdxW];

  assign inv_match = inv_en_i && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag);

  // A lookup racing an invalidate of the same line must report a miss.
  assign lookup_hit_o  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) &&
                         !(inv_match && (inv_idx == lk_idx));
  assign lookup_data_o = data_q[lk_idx];

  always_comb begin
    valid_d = valid_q;
    if (inv_match) valid_d[inv_idx] = 1'b0;
    if (wr_en_i)   valid_d[lk_idx]  = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      tag_q[lk_idx]  <= lk_tag;
      data_q[lk_idx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/snoop_cache.sv
// Write-invalidate snooping cache: request FSM, bus transmit register and response registers.
// Snoop decode runs every cycle regardless of FSM state.
module snoop_cache
  import cache_pkg::*;
#(
  parameter int unsigned SET_COUNT   = 4,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned LINE_WIDTH  = 32,
  parameter int unsigned ID_WIDTH    = 2,
  parameter int unsigned ID          = 0,
  parameter int unsigned BCAST_READS = 0
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_write_i,
  input  logic [ADDR_WIDTH-1:0]        req_addr_i,
  input  logic [LINE_WIDTH-1:0]        req_data_i,
  output logic                         resp_valid_o,
  output logic                         resp_hit_o,
  output logic [LINE_WIDTH-1:0]        resp_data_o,
  output logic                         bus_tx_valid_o,
  input  logic                         bus_tx_ready_i,
  output logic [ID_WIDTH+ADDR_WIDTH:0] bus_tx_msg_o,
  input  logic                         bus_rx_valid_i,
  input  logic [ID_WIDTH+ADDR_WIDTH:0] bus_rx_msg_i
);

  localparam int unsigned MsgW  = msg_width(ID_WIDTH, ADDR_WIDTH);
  localparam int unsigned OpBit = msg_op_bit(ADDR_WIDTH);
  localparam int unsigned IdLsb = msg_id_lsb(ADDR_WIDTH);
  localparam logic [ID_WIDTH-1:0] IdBits = ID_WIDTH'(ID);

  if (ID >= (32'd1 << ID_WIDTH)) begin : g_bad_id
    $error("snoop_cache: ID does not fit in ID_WIDTH");
  end
  if (SET_COUNT < 2 || (SET_COUNT & (SET_COUNT - 1)) != 0) begin : g_bad_sets
    $error("snoop_cache: SET_COUNT must be a power of two >= 2");
  end

  state_e                state_q;
  logic                  req_ready_q;
  logic                  resp_valid_q, resp_hit_q;
  logic [LINE_WIDTH-1:0] resp_data_q;
  logic                  tx_valid_q;
  logic [MsgW-1:0]       tx_msg_q;

  logic                  accept;
  logic                  lookup_hit;
  logic [LINE_WIDTH-1:0] lookup_data;
  logic [ID_WIDTH-1:0]   rx_id;
  bus_op_e               rx_op, tx_op;
  logic                  snoop_inv;

  assign rx_id     = bus_rx_msg_i[IdLsb +: ID_WIDTH];
  assign rx_op     = bus_op_e'(bus_rx_msg_i[OpBit]);
  assign snoop_inv = bus_rx_valid_i && (rx_op == BUS_WRITE) && (rx_id != IdBits);

  assign accept = req_valid_i && req_ready_q;
  assign tx_op  = req_write_i ? BUS_WRITE : BUS_READ;

  cache_line_store #(
    .SET_COUNT (SET_COUNT),
    .ADDR_WIDTH(ADDR_WIDTH),
    .LINE_WIDTH(LINE_WIDTH)
  ) u_store (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .lookup_addr_i(req_addr_i),
    .lookup_hit_o (lookup_hit),
    .lookup_data_o(lookup_data),
    .wr_en_i      (accept && req_write_i),
    .wr_data_i    (req_data_i),
    .inv_en_i     (snoop_inv),
    .inv_addr_i   (bus_rx_msg_i[ADDR_WIDTH-1:0])
  );

  // The response is captured at acceptance so later snoops cannot alter a read's result.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
      tx_valid_q   <= 1'b0;
      tx_msg_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            resp_hit_q  <= req_write_i | lookup_hit;
            resp_data_q <= req_write_i ? req_data_i : (lookup_hit ? lookup_data : '0);
            if (req_write_i || (BCAST_READS != 0)) begin
              state_q    <= ST_SEND;
              tx_valid_q <= 1'b1;
              tx_msg_q   <= {IdBits, tx_op, req_addr_i};
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_SEND: begin
          if (bus_tx_ready_i) begin
            tx_valid_q   <= 1'b0;
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o    = req_ready_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_hit_o     = resp_hit_q;
  assign resp_data_o    = resp_data_q;
  assign bus_tx_valid_o = tx_valid_q;
  assign bus_tx_msg_o   = tx_msg_q;

endmodule

// File: tb/tb_snoop_cache.sv
// Scoreboard bench for snoop_cache: dut0 has silent reads (ID 0), dut1 broadcasts reads (ID 2).
module tb_snoop_cache;

  typedef struct {
    int          k;
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    int          dly;
    logic        pre_v;
    logic [10:0] pre_m;
    logic        co_v;
    logic [10:0] co_m;
    logic        hit;
    logic [31:0] data;
    int          lat;
    int          txc;
    logic [10:0] msg;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_write    [2];
  logic [7:0]  req_addr     [2];
  logic [31:0] req_data     [2];
  logic        resp_valid   [2];
  logic        resp_hit     [2];
  logic [31:0] resp_data    [2];
  logic        bus_tx_valid [2];
  logic        bus_tx_ready [2];
  logic [10:0] tx_msg       [2];
  logic        rx_valid     [2];
  logic [10:0] rx_msg       [2];

  int   asserts = 0;
  int   fails   = 0;
  req_t sb[$];

  snoop_cache #(.SET_COUNT(4), .ADDR_WIDTH(8), .LINE_WIDTH(32), .ID_WIDTH(2), .ID(0),
                .BCAST_READS(0)) dut0 (
    .clock_i(clk), .reset_i(rst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_write_i(req_write[0]), .req_addr_i(req_addr[0]), .req_data_i(req_data[0]),
    .resp_valid_o(resp_valid[0]), .resp_hit_o(resp_hit[0]), .resp_data_o(resp_data[0]),
    .bus_tx_valid_o(bus_tx_valid[0]), .bus_tx_ready_i(bus_tx_ready[0]),
    .bus_tx_msg_o(tx_msg[0]), .bus_rx_valid_i(rx_valid[0]), .bus_rx_msg_i(rx_msg[0])
  );

  snoop_cache #(.SET_COUNT(4), .ADDR_WIDTH(8), .LINE_WIDTH(32), .ID_WIDTH(2), .ID(2),
                .BCAST_READS(1)) dut1 (
    .clock_i(clk), .reset_i(rst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_write_i(req_write[1]), .req_addr_i(req_addr[1]), .req_data_i(req_data[1]),
    .resp_valid_o(resp_valid[1]), .resp_hit_o(resp_hit[1]), .resp_data_o(resp_data[1]),
    .bus_tx_valid_o(bus_tx_valid[1]), .bus_tx_ready_i(bus_tx_ready[1]),
    .bus_tx_msg_o(tx_msg[1]), .bus_rx_valid_i(rx_valid[1]), .bus_rx_msg_i(rx_msg[1])
  );

  // Expected latency, bus traffic and message derive from the request kind alone.
  function automatic req_t mk(input int k, input logic wr, input logic [7:0] a,
                              input logic [31:0] d, input int dly, input logic pre_v,
                              input logic [10:0] pre_m, input logic co_v, input logic [10:0] co_m,
                              input logic hit, input logic [31:0] data);
    req_t r;
    logic bused;
    bused   = wr || (k == 1);
    r.k     = k;      r.wr    = wr;    r.a    = a;    r.d    = d;    r.dly = dly;
    r.pre_v = pre_v;  r.pre_m = pre_m; r.co_v = co_v; r.co_m = co_m;
    r.hit   = hit;    r.data  = data;
    r.lat   = bused ? dly + 2 : 1;
    r.txc   = bused ? dly + 1 : 0;
    r.msg   = {(k == 1) ? 2'd2 : 2'd0, wr, a};
    return r;
  endfunction

  task automatic snoop(input int k, input logic [10:0] m);
    rx_valid[k] = 1'b1;
    rx_msg[k]   = m;
    @(negedge clk);
    rx_valid[k] = 1'b0;
  endtask

  task automatic do_req(input req_t r, output logic ok, output logic hit, output logic [31:0] rd,
                        output int lat, output int txc, output logic [10:0] msg,
                        output logic stable, output int rdy_seen);
    int k;
    k = r.k;
    ok = 1'b0; hit = 1'b0; rd = '0; lat = 0; txc = 0; msg = '0; stable = 1'b1; rdy_seen = 0;
    for (int c = 0; c < 10 && !req_ready[k]; c++) @(negedge clk);
    req_valid[k] = 1'b1; req_write[k] = r.wr; req_addr[k] = r.a; req_data[k] = r.d;
    rx_valid[k]  = r.co_v; rx_msg[k] = r.co_m;
    @(negedge clk);
    req_valid[k] = 1'b0; rx_valid[k] = 1'b0;
    lat = 1;
    for (int c = 0; c < 40; c++) begin
      if (resp_valid[k]) begin
        ok = 1'b1; hit = resp_hit[k]; rd = resp_data[k];
        break;
      end
      if (req_ready[k]) rdy_seen++;
      if (bus_tx_valid[k]) begin
        if (txc == 0) msg = tx_msg[k];
        else if (tx_msg[k] !== msg) stable = 1'b0;
        txc++;
        bus_tx_ready[k] = (txc > r.dly);
      end
      @(negedge clk);
      lat++;
    end
    bus_tx_ready[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
      req_data[k] = '0; bus_tx_ready[k] = 1'b0; rx_valid[k] = 1'b0; rx_msg[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      asserts++; if (req_ready[k] !== 1'b0) begin fails++;
        $display("FAIL reset[%0d] req_ready: got %b required 0", k, req_ready[k]); end
      asserts++; if (resp_valid[k] !== 1'b0 || resp_hit[k] !== 1'b0) begin fails++;
        $display("FAIL reset[%0d] resp_valid/hit: got %b/%b required 0/0", k, resp_valid[k],
                 resp_hit[k]); end
      asserts++; if (resp_data[k] !== 32'h0) begin fails++;
        $display("FAIL reset[%0d] resp_data: got %h required 0", k, resp_data[k]); end
      asserts++; if (bus_tx_valid[k] !== 1'b0 || tx_msg[k] !== 11'h0) begin fails++;
        $display("FAIL reset[%0d] bus_tx: got %b/%h required 0/0", k, bus_tx_valid[k],
                 tx_msg[k]); end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      asserts++; if (req_ready[k] !== 1'b1) begin fails++;
        $display("FAIL reset_release[%0d] req_ready: got %b required 1", k, req_ready[k]); end
    end
  endtask

  task automatic test_basic();
    req_t tbl[$]; req_t e; logic ok, hit, stable; logic [31:0] rd; int lat, txc, rs;
    logic [10:0] msg;
    tbl.push_back(mk(0, 1'b0, 8'h05, 32'h0, 0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0, 32'h0));
    tbl.push_back(mk(0, 1'b1, 8'h05, 32'hDEADBEEF, 3, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1,
                     32'hDEADBEEF));
    tbl.push_back(mk(0, 1'b0, 8'h05, 32'h0, 0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 32'hDEADBEEF));
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      do_req(tbl[i], ok, hit, rd, lat, txc, msg, stable, rs);
      e = sb.pop_front();
      asserts++;
      if (ok !== 1'b1) begin fails++;
        $display("FAIL basic[%0d] resp_valid: got none required within 40 cycles", i); end
      else begin
        asserts++; if (hit !== e.hit) begin fails++;
          $display("FAIL basic[%0d] resp_hit: got %b required %b", i, hit, e.hit); end
        asserts++; if (rd !== e.data) begin fails++;
          $display("FAIL basic[%0d] resp_data: got %h required %h", i, rd, e.data); end
        asserts++; if (lat !== e.lat) begin fails++;
          $display("FAIL basic[%0d] latency: got %0d required %0d", i, lat, e.lat); end
        asserts++; if (txc !== e.txc) begin fails++;
          $display("FAIL basic[%0d] bus_tx cycles: got %0d required %0d", i, txc, e.txc); end
        asserts++; if (rs !== 0) begin fails++;
          $display("FAIL basic[%0d] req_ready while busy: got %0d cycles required 0", i, rs); end
        if (e.txc != 0) begin
          asserts++; if (msg !== e.msg || stable !== 1'b1) begin fails++;
            $display("FAIL basic[%0d] bus_tx_msg: got %h stable %b required %h stable 1", i,
                     msg, stable, e.msg); end
        end
      end
    end
  endtask

  task automatic test_snoop();
    req_t tbl[$]; req_t e; logic ok, hit, stable; logic [31:0] rd; int lat, txc, rs;
    logic [10:0] msg;
    tbl.push_back(mk(0, 1'b0, 8'h05, 32'h0, 0, 1'b1, 11'h309, 1'b0, 11'h0, 1'b1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1'b0, 8'h05, 32'h0, 0, 1'b1, 11'h105, 1'b0, 11'h0, 1'b1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1'b0, 8'h05, 32'h0, 0, 1'b1, 11'h205, 1'b0, 11'h0, 1'b1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1'b0, 8'h05, 32'h0, 0, 1'b1, 11'h305, 1'b0, 11'h0, 1'b0, 32'h0));
    tbl.push_back(mk(0, 1'b1, 8'h0A, 32'h55, 0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 32'h55));
    tbl.push_back(mk(0, 1'b0, 8'h0A, 32'h0, 0, 1'b0, 11'h0, 1'b1, 11'h30B, 1'b1, 32'h55));
    tbl.push_back(mk(0, 1'b0, 8'h0A, 32'h0, 0, 1'b0, 11'h0, 1'b1, 11'h30A, 1'b0, 32'h0));
    tbl.push_back(mk(0, 1'b0, 8'h0A, 32'h0, 0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0, 32'h0));
    foreach (tbl[i]) begin
      if (tbl[i].pre_v) snoop(tbl[i].k, tbl[i].pre_m);
      sb.push_back(tbl[i]);
      do_req(tbl[i], ok, hit, rd, lat, txc, msg, stable, rs);
      e = sb.pop_front();
      asserts++;
      if (ok !== 1'b1) begin fails++;
        $display("FAIL snoop[%0d] resp_valid: got none required within 40 cycles", i); end
      else begin
        asserts++; if (hit !== e.hit) begin fails++;
          $display("FAIL snoop[%0d] resp_hit: got %b required %b", i, hit, e.hit); end
        asserts++; if (rd !== e.data) begin fails++;
          $display("FAIL snoop[%0d] resp_data: got %h required %h", i, rd, e.data); end
        asserts++; if (lat !== e.lat || txc !== e.txc) begin fails++;
          $display("FAIL snoop[%0d] latency/tx: got %0d/%0d required %0d/%0d", i, lat, txc,
                   e.lat, e.txc); end
      end
    end
  endtask

  task automatic test_same_edge();
    req_t tbl[$]; req_t e; logic ok, hit, stable; logic [31:0] rd; int lat, txc, rs;
    logic [10:0] msg;
    tbl.push_back(mk(0, 1'b1, 8'h06, 32'h1111, 0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 32'h1111));
    tbl.push_back(mk(0, 1'b1, 8'h06, 32'h1234, 1, 1'b0, 11'h0, 1'b1, 11'h306, 1'b1, 32'h1234));
    tbl.push_back(mk(0, 1'b0, 8'h06, 32'h0, 0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 32'h1234));
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      do_req(tbl[i], ok, hit, rd, lat, txc, msg, stable, rs);
      e = sb.pop_front();
      asserts++;
      if (ok !== 1'b1) begin fails++;
        $display("FAIL same_edge[%0d] resp_valid: got none required within 40 cycles", i); end
      else begin
        asserts++; if (hit !== e.hit || rd !== e.data) begin fails++;
          $display("FAIL same_edge[%0d] resp: got %b/%h required %b/%h", i, hit, rd, e.hit,
                   e.data); end
        asserts++; if (lat !== e.lat) begin fails++;
          $display("FAIL same_edge[%0d] latency: got %0d required %0d", i, lat, e.lat); end
      end
    end
  endtask

  task automatic test_bcast_reads();
    req_t tbl[$]; req_t e; logic ok, hit, stable; logic [31:0] rd; int lat, txc, rs;
    logic [10:0] msg;
    tbl.push_back(mk(1, 1'b0, 8'h07, 32'h0, 2, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0, 32'h0));
    tbl.push_back(mk(1, 1'b1, 8'h07, 32'hCAFE, 1, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 32'hCAFE));
    tbl.push_back(mk(1, 1'b0, 8'h07, 32'h0, 0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 32'hCAFE));
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      do_req(tbl[i], ok, hit, rd, lat, txc, msg, stable, rs);
      e = sb.pop_front();
      asserts++;
      if (ok !== 1'b1) begin fails++;
        $display("FAIL bcast[%0d] resp_valid: got none required within 40 cycles", i); end
      else begin
        asserts++; if (hit !== e.hit || rd !== e.data) begin fails++;
          $display("FAIL bcast[%0d] resp: got %b/%h required %b/%h", i, hit, rd, e.hit,
                   e.data); end
        asserts++; if (lat !== e.lat || txc !== e.txc) begin fails++;
          $display("FAIL bcast[%0d] latency/tx: got %0d/%0d required %0d/%0d", i, lat, txc,
                   e.lat, e.txc); end
        asserts++; if (msg !== e.msg || stable !== 1'b1) begin fails++;
          $display("FAIL bcast[%0d] bus_tx_msg: got %h stable %b required %h stable 1", i,
                   msg, stable, e.msg); end
        asserts++; if (rs !== 0) begin fails++;
          $display("FAIL bcast[%0d] req_ready while busy: got %0d cycles required 0", i, rs); end
      end
    end
  endtask

  task automatic test_reset_in_send();
    req_t tbl[$]; req_t e; logic ok, hit, stable; logic [31:0] rd; int lat, txc, rs, seen;
    logic [10:0] msg;
    for (int c = 0; c < 10 && !req_ready[0]; c++) @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h09; req_data[0] = 32'h77;
    @(negedge clk);
    req_valid[0] = 1'b0;
    asserts++; if (bus_tx_valid[0] !== 1'b1) begin fails++;
      $display("FAIL rst_send bus_tx_valid before reset: got %b required 1", bus_tx_valid[0]); end
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    asserts++; if (bus_tx_valid[0] !== 1'b0) begin fails++;
      $display("FAIL rst_send bus_tx_valid: got %b required 0", bus_tx_valid[0]); end
    asserts++; if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin fails++;
      $display("FAIL rst_send resp_valid/req_ready: got %b/%b required 0/0", resp_valid[0],
               req_ready[0]); end
    rst[0] = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid[0]) seen++;
    end
    asserts++; if (seen !== 0) begin fails++;
      $display("FAIL rst_send stray resp_valid: got %0d pulses required 0", seen); end
    tbl.push_back(mk(0, 1'b0, 8'h06, 32'h0, 0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0, 32'h0));
    tbl.push_back(mk(0, 1'b0, 8'h09, 32'h0, 0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0, 32'h0));
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      do_req(tbl[i], ok, hit, rd, lat, txc, msg, stable, rs);
      e = sb.pop_front();
      asserts++;
      if (ok !== 1'b1 || hit !== e.hit || rd !== e.data) begin fails++;
        $display("FAIL rst_send_read[%0d] resp: got ok %b %b/%h required ok 1 %b/%h", i, ok,
                 hit, rd, e.hit, e.data); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_snoop();
    test_same_edge();
    test_bcast_reads();
    test_reset_in_send();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
